// File: rtl/busprobe_pkg.sv
// busprobe_pkg: constants and types shared by the bus-probe transmitter and receiver
package busprobe_pkg;
  localparam int LANE_BITS_DEF = 8;
  localparam int NUM_LANES = 5;
  localparam int ADDRX = 4;
  localparam int ADDRH = 3;
  localparam int ADDRL = 2;
  localparam int DATAH = 1;
  localparam int DATAL = 0;
  localparam int REC_W = 40;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/busprobe_rx_fifo.sv
// sync_fifo: width/depth parameterised synchronous FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_do_pop, w_do_push;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data = r_mem[r_rd[AW-1:0]];
  // pointer update; a push into a full FIFO is allowed when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end
  // storage, cleared on reset so the head output reads zero after reset
  always_ff @(posedge clk) begin
    if (reset) r_mem <= '{default: '0};
    else if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/busprobe_rx.sv
// busprobe_rx: deserialises the five-lane bus-probe stream into buffered address/data records
module busprobe_rx
  import busprobe_pkg::*;
#(
  parameter int LANE_BITS = LANE_BITS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        addrx_si,
  input  logic        addrh_si,
  input  logic        addrl_si,
  input  logic        datah_si,
  input  logic        datal_si,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [23:0] rec_addr,
  output logic [15:0] rec_data,
  output logic        frame_err,
  output logic        overflow,
  input  logic        clr_status,
  output logic [15:0] frame_cnt
);
  localparam int CW = $clog2(LANE_BITS + 2);
  localparam int IN_W = NUM_LANES + 2;
  localparam int CSN = NUM_LANES;
  localparam int SCLK = NUM_LANES + 1;
  logic [SYNC_STAGES-1:0][IN_W-1:0] r_sync;
  logic [IN_W-1:0] w_in, w_synced;
  logic [NUM_LANES-1:0] r_lane;
  logic r_sclk, r_cs, r_sclk_rise, r_cs_fall, r_cs_rise;
  state_t r_state, w_next;
  logic [CW-1:0] r_bitcnt;
  logic [NUM_LANES-1:0][LANE_BITS-1:0] r_sh;
  logic [REC_W-1:0] w_rec, w_head;
  logic w_good, w_pop, w_push, w_full, w_empty;
  logic r_overflow;
  logic [15:0] r_frame_cnt;
  assign w_in[SCLK] = sclk_i;
  assign w_in[CSN] = cs_n_i;
  assign w_in[ADDRX] = addrx_si;
  assign w_in[ADDRH] = addrh_si;
  assign w_in[ADDRL] = addrl_si;
  assign w_in[DATAH] = datah_si;
  assign w_in[DATAL] = datal_si;
  assign w_synced = r_sync[SYNC_STAGES-1];
  // equal-depth synchronisers keep the data lanes aligned with sclk and cs_n
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else begin
      r_sync[0] <= w_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end
  // registered edge pulses, with the lane bits registered alongside so they line up with sclk_rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane <= '0;
      r_sclk <= 1'b0;
      r_cs <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_cs_fall <= 1'b0;
      r_cs_rise <= 1'b0;
    end else begin
      r_lane <= w_synced[NUM_LANES-1:0];
      r_sclk <= w_synced[SCLK];
      r_cs <= w_synced[CSN];
      r_sclk_rise <= w_synced[SCLK] && !r_sclk;
      r_cs_fall <= !w_synced[CSN] && r_cs;
      r_cs_rise <= w_synced[CSN] && !r_cs;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_IDLE;
    else r_state <= w_next;
  end
  // next state; WAIT_IDLE skips any frame already under way when reset releases
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_IDLE: w_next = r_cs ? IDLE : WAIT_IDLE;
      IDLE:      w_next = r_cs_fall ? SHIFT : IDLE;
      SHIFT:     w_next = r_cs_rise ? COMMIT : SHIFT;
      default:   w_next = IDLE;
    endcase
  end
  // commit outputs: a frame is good only with exactly LANE_BITS sclk rises
  always_comb begin
    w_good = r_state == COMMIT && r_bitcnt == CW'(LANE_BITS);
    frame_err = r_state == COMMIT && !w_good;
  end
  // lane shifters and saturating bit counter; a final sclk rise coincident with cs rise still counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_sh <= '0;
    end else if (r_state == IDLE && r_cs_fall) r_bitcnt <= '0;
    else if (r_state == SHIFT && r_sclk_rise) begin
      for (int l = 0; l < NUM_LANES; l++) r_sh[l] <= {r_sh[l][LANE_BITS-2:0], r_lane[l]};
      if (r_bitcnt != CW'(LANE_BITS + 1)) r_bitcnt <= r_bitcnt + 1'b1;
    end
  end
  assign w_rec = r_sh;
  assign w_pop = !w_empty && rec_ready;
  assign w_push = w_good && (!w_full || w_pop);
  // good-frame counter and sticky overflow; a drop in the same cycle as clr_status keeps overflow set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_overflow <= (w_good && !w_push) ? 1'b1 : clr_status ? 1'b0 : r_overflow;
    end
  end
  sync_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign rec_valid = !w_empty;
  assign rec_addr = w_head[39:16];
  assign rec_data = w_head[15:0];
  assign overflow = r_overflow;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_busprobe_rx.sv
// tb_busprobe_rx: randomized and directed stimulus against a queue-based reference model
module tb_busprobe_rx;
  localparam int H = 5;
  localparam int GAP = 10;
  localparam int DEPTH = 4;
  localparam int SS = 2;
  logic clk = 1'b0, reset = 1'b1, sclk_i = 1'b0, cs_n_i = 1'b1;
  logic addrx_si = 1'b0, addrh_si = 1'b0, addrl_si = 1'b0, datah_si = 1'b0, datal_si = 1'b0;
  logic rec_ready = 1'b0, clr_status = 1'b0;
  logic rec_valid, frame_err, overflow;
  logic [23:0] rec_addr;
  logic [15:0] rec_data, frame_cnt;
  int n_chk = 0, n_fail = 0, n_err = 0;
  logic [39:0] q[$];
  int m_cnt = 0, cd = 0, pend_n = -1, cur_n = -1;
  logic [39:0] pend_rec = '0, cur_rec = '0;
  logic m_ovf = 1'b0, rst_q = 1'b1, cs_prev = 1'b1, commit, set_ovf;
  bit rdy_rand = 1'b0;
  always #5 clk = ~clk;
  busprobe_rx #(.LANE_BITS(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sclk_i(sclk_i), .cs_n_i(cs_n_i),
    .addrx_si(addrx_si), .addrh_si(addrh_si), .addrl_si(addrl_si),
    .datah_si(datah_si), .datal_si(datal_si),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr), .rec_data(rec_data),
    .frame_err(frame_err), .overflow(overflow), .clr_status(clr_status), .frame_cnt(frame_cnt)
  );
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) rst_q <= reset;
  always @(negedge clk) if (frame_err === 1'b1) n_err++;
  // reference model: FIFO as a queue, a commit 3 cycles after the first clk edge that sees cs_n_i high
  always @(negedge clk) begin
    if (rst_q) begin
      q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      cd = 0;
      chk("rst_valid", 40'(rec_valid), 40'(0));
      chk("rst_cnt", 40'(frame_cnt), 40'(0));
      chk("rst_ovf", 40'(overflow), 40'(0));
      chk("rst_ferr", 40'(frame_err), 40'(0));
    end else begin
      chk("valid", 40'(rec_valid), 40'(q.size() != 0));
      if (q.size() != 0) begin
        chk("head_addr", 40'(rec_addr), 40'(q[0][39:16]));
        chk("head_data", 40'(rec_data), 40'(q[0][15:0]));
      end
      chk("frame_cnt", 40'(frame_cnt), 40'(16'(m_cnt)));
      chk("overflow", 40'(overflow), 40'(m_ovf));
      commit = 1'b0;
      if (cd > 0) begin
        cd--;
        commit = cd == 0;
      end
      chk("frame_err", 40'(frame_err), 40'(commit && cur_n >= 0 && cur_n != 8));
      if (rec_ready && q.size() != 0) void'(q.pop_front());
      set_ovf = 1'b0;
      if (commit && cur_n == 8) begin
        if (q.size() < DEPTH) begin
          q.push_back(cur_rec);
          m_cnt++;
        end else set_ovf = 1'b1;
      end
      m_ovf = set_ovf ? 1'b1 : clr_status ? 1'b0 : m_ovf;
      if (cs_n_i && !cs_prev) begin
        cd = 4;
        cur_n = pend_n;
        cur_rec = pend_rec;
      end
    end
    cs_prev = cs_n_i;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rdy_rand) rec_ready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic put_bit(input logic [39:0] rec, input int i);
    logic [4:0] w;
    for (int l = 0; l < 5; l++) w[l] = (i < 8) ? rec[l*8+7-i] : 1'($urandom_range(0, 1));
    {addrx_si, addrh_si, addrl_si, datah_si, datal_si} = w;
  endtask
  task automatic shift_bits(input logic [39:0] rec, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      put_bit(rec, i);
      tick(H);
      sclk_i = 1'b1;
      tick(H);
      sclk_i = 1'b0;
    end
  endtask
  task automatic send(input logic [39:0] rec, input int nb, input bit coinc, input bit prdy, input bit meas);
    int lat;
    pend_rec = rec;
    pend_n = nb;
    cs_n_i = 1'b0;
    tick(H);
    shift_bits(rec, 0, coinc ? nb - 1 : nb);
    if (coinc) begin
      put_bit(rec, nb - 1);
      tick(H);
      sclk_i = 1'b1;
      cs_n_i = 1'b1;
    end else begin
      tick(H);
      cs_n_i = 1'b1;
    end
    if (meas) begin
      lat = -1;
      for (int t = 0; t < 20 && lat < 0; t++) begin
        @(posedge clk);
        #1;
        if (rec_valid) lat = t;
      end
      chk("latency", 40'(lat), 40'(SS + 2));
    end
    if (prdy) begin
      tick(4);
      rec_ready = 1'b1;
      tick(1);
      rec_ready = 1'b0;
    end
    tick(GAP);
    sclk_i = 1'b0;
    tick(GAP);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(6);
  endtask
  initial begin
    int e0, nb;
    logic [39:0] r;
    do_reset();
    chk("reset_valid", 40'(rec_valid), 40'(0));
    chk("reset_addr", 40'(rec_addr), 40'(0));
    chk("reset_data", 40'(rec_data), 40'(0));
    chk("reset_cnt", 40'(frame_cnt), 40'(0));
    rec_ready = 1'b1;
    send({24'h123456, 16'hBEEF}, 8, 1'b0, 1'b0, 1'b1);
    chk("good_cnt", 40'(frame_cnt), 40'(1));
    do_reset();
    e0 = n_err;
    send({24'h0F0F0F, 16'h5555}, 7, 1'b0, 1'b0, 1'b0);
    send({24'hF0F0F0, 16'hAAAA}, 9, 1'b0, 1'b0, 1'b0);
    chk("err_pulses", 40'(n_err - e0), 40'(2));
    chk("err_cnt", 40'(frame_cnt), 40'(0));
    chk("err_valid", 40'(rec_valid), 40'(0));
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) send({24'(i), 16'(16'h100 + i)}, 8, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 40'(overflow), 40'(1));
    chk("ovf_cnt", 40'(frame_cnt), 40'(4));
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    tick(1);
    chk("ovf_clr", 40'(overflow), 40'(0));
    rec_ready = 1'b1;
    tick(10);
    chk("ovf_drained", 40'(rec_valid), 40'(0));
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({24'(24'h200 + i), 16'(i)}, 8, 1'b0, 1'b0, 1'b0);
    send({24'hAAAAAA, 16'h5A5A}, 8, 1'b0, 1'b1, 1'b0);
    chk("pp_ovf", 40'(overflow), 40'(0));
    chk("pp_cnt", 40'(frame_cnt), 40'(9));
    rec_ready = 1'b1;
    tick(10);
    r = {24'hFFFFFF, 16'hFFFF};
    pend_n = -1;
    cs_n_i = 1'b0;
    tick(H);
    shift_bits(r, 0, 4);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    shift_bits(r, 4, 8);
    tick(H);
    cs_n_i = 1'b1;
    tick(GAP);
    chk("mid_none", 40'(rec_valid), 40'(0));
    send({24'h00FF00, 16'h1234}, 8, 1'b0, 1'b0, 1'b0);
    chk("mid_cnt", 40'(frame_cnt), 40'(1));
    send({24'hC0FFE1, 16'h8001}, 8, 1'b1, 1'b0, 1'b0);
    chk("coinc_cnt", 40'(frame_cnt), 40'(2));
    rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 11)) : 8;
      r = {8'($urandom), 32'($urandom)};
      send(r, nb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    rdy_rand = 1'b0;
    rec_ready = 1'b1;
    tick(20);
    chk("final_empty", 40'(rec_valid), 40'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
